// File: rtl/rv32_multicycle_core.sv
// Multicycle RV32I subset core: handshaked instruction fetch with a timeout,
// internal register file, and halt/error states visible to a debug harness.
module rv32_multicycle_core #(
    parameter int PC_W     = 8,
    parameter int NREG     = 32,
    parameter int END_PC   = 255,
    parameter int WAIT_MAX = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_valid,
    output logic            done,
    output logic            err,
    output logic [PC_W-1:0] pc,
    input  logic [4:0]      dbg_addr,
    output logic [31:0]     dbg_data
);

    localparam int          RW    = $clog2(NREG);
    localparam int          CW    = $clog2(WAIT_MAX + 1);
    localparam logic [31:0] END_W = 32'(END_PC);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_WAIT, S_EXECUTE, S_WRITEBACK, S_DONE, S_ERROR
    } state_t;

    state_t                     state;
    logic [31:0]                ir;
    logic [CW-1:0]              wcnt;
    logic [NREG-1:0][31:0]      regs;
    logic [31:0]                res_q;
    logic [PC_W-1:0]            npc_q;
    logic                       wr_q;
    logic [4:0]                 rd_q;

    logic [6:0]  opc, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_b, imm_j, imm_u, rs1v, rs2v;
    logic        bad_rd, bad_rs1, bad_rs2;
    logic [31:0] res;
    logic [PC_W-1:0] npc;
    logic        wr, ill, brk, taken;

    assign opc = ir[6:0];
    assign rd  = ir[11:7];
    assign f3  = ir[14:12];
    assign rs1 = ir[19:15];
    assign rs2 = ir[24:20];
    assign f7  = ir[31:25];

    assign imm_i = {{20{ir[31]}}, ir[31:20]};
    assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    assign imm_u = {ir[31:12], 12'b0};

    assign bad_rd  = {1'b0, rd}  >= 6'(NREG);
    assign bad_rs1 = {1'b0, rs1} >= 6'(NREG);
    assign bad_rs2 = {1'b0, rs2} >= 6'(NREG);

    assign rs1v = bad_rs1 ? 32'd0 : regs[rs1[RW-1:0]];
    assign rs2v = bad_rs2 ? 32'd0 : regs[rs2[RW-1:0]];

    // Byte offsets are converted to word offsets; the sum wraps modulo 2^PC_W.
    function automatic logic [PC_W-1:0] pc_add(input logic [PC_W-1:0] p, input logic [31:0] imm);
        return PC_W'(32'(p) + 32'($signed(imm) >>> 2));
    endfunction

    function automatic logic [31:0] alu(input logic [2:0] op, input logic alt,
                                        input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'b000:  return alt ? a - b : a + b;
            3'b001:  return a << b[4:0];
            3'b010:  return {31'b0, $signed(a) < $signed(b)};
            3'b011:  return {31'b0, a < b};
            3'b100:  return a ^ b;
            3'b101:  return alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'b110:  return a | b;
            default: return a & b;
        endcase
    endfunction

    always_comb begin
        res   = 32'd0;
        npc   = pc + PC_W'(1);
        wr    = 1'b0;
        ill   = 1'b0;
        brk   = 1'b0;
        taken = 1'b0;
        case (opc)
            OPC_OP: begin
                wr  = 1'b1;
                res = alu(f3, ir[30], rs1v, rs2v);
                ill = bad_rd || bad_rs1 || bad_rs2 ||
                      !(f7 == 7'h00 || f7 == 7'h20) ||
                      (f7 == 7'h20 && f3 != 3'b000 && f3 != 3'b101);
            end
            OPC_OPIMM: begin
                wr  = 1'b1;
                // Only the right shift uses bit 30 as a selector; ADDI never subtracts.
                res = alu(f3, (f3 == 3'b101) && ir[30], rs1v, imm_i);
                ill = bad_rd || bad_rs1;
            end
            OPC_LUI: begin
                wr  = 1'b1;
                res = imm_u;
                ill = bad_rd;
            end
            OPC_BRANCH: begin
                case (f3)
                    3'b000:  taken = rs1v == rs2v;
                    3'b001:  taken = rs1v != rs2v;
                    3'b100:  taken = $signed(rs1v) <  $signed(rs2v);
                    3'b101:  taken = $signed(rs1v) >= $signed(rs2v);
                    3'b110:  taken = rs1v <  rs2v;
                    3'b111:  taken = rs1v >= rs2v;
                    default: taken = 1'b0;
                endcase
                ill = bad_rs1 || bad_rs2 || f3 == 3'b010 || f3 == 3'b011 || imm_b[1];
                if (taken) npc = pc_add(pc, imm_b);
            end
            OPC_JAL: begin
                wr  = 1'b1;
                res = (32'(pc) + 32'd1) << 2;
                npc = pc_add(pc, imm_j);
                ill = bad_rd || imm_j[1];
            end
            OPC_SYSTEM: begin
                brk = ir == 32'h0010_0073;
                ill = !brk;
            end
            default: ill = 1'b1;
        endcase
    end

    always_comb begin
        dbg_data = 32'd0;
        if ({1'b0, dbg_addr} < 6'(NREG)) dbg_data = regs[dbg_addr[RW-1:0]];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            pc        <= '0;
            imem_req  <= 1'b0;
            imem_addr <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            ir        <= '0;
            wcnt      <= '0;
            regs      <= '0;
            res_q     <= '0;
            npc_q     <= '0;
            wr_q      <= 1'b0;
            rd_q      <= '0;
        end else begin
            imem_req <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    pc        <= '0;
                    imem_addr <= '0;
                    imem_req  <= 1'b1;
                    state     <= S_FETCH;
                end
                S_FETCH: begin
                    wcnt  <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (imem_valid) begin
                        ir    <= imem_rdata;
                        state <= S_EXECUTE;
                    end else begin
                        wcnt <= wcnt + CW'(1);
                        if (wcnt == CW'(WAIT_MAX - 1)) begin
                            err   <= 1'b1;
                            state <= S_ERROR;
                        end
                    end
                end
                S_EXECUTE: begin
                    if (brk) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (ill) begin
                        err   <= 1'b1;
                        state <= S_ERROR;
                    end else begin
                        res_q <= res;
                        npc_q <= npc;
                        wr_q  <= wr;
                        rd_q  <= rd;
                        state <= S_WRITEBACK;
                    end
                end
                S_WRITEBACK: begin
                    // regs[0] is never written, so x0 reads as zero.
                    if (wr_q && rd_q != 5'd0) regs[rd_q[RW-1:0]] <= res_q;
                    pc <= npc_q;
                    if (32'(npc_q) == END_W) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        imem_addr <= npc_q;
                        imem_req  <= 1'b1;
                        state     <= S_FETCH;
                    end
                end
                S_DONE: if (!start) begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                S_ERROR: if (!start) begin
                    err   <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/rv32_multicycle_core.md
Name: rv32_multicycle_core

Overview:
- Parametrised successor to the existing multicycle RV32 core.
- Adds an external instruction-memory handshake with a wait timeout and an internal register file with x0 hardwired to zero.
- Adds correctly sign-extended immediates, LUI, BRANCH, JAL, an EBREAK/END_PC halt, and an error state for illegal instructions.
- Sits between the instruction ROM wrapper and the debug/test harness.

Parameters:
- PC_W, 8, width of the word-indexed program counter and imem_addr.
- NREG, 32, number of architectural registers; 32 or 16 (RV32E).
- END_PC, 255, word address; completing WRITEBACK with next PC == END_PC halts.
- WAIT_MAX, 15, maximum cycles in WAIT without imem_valid before the core enters ERROR.

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-low reset
- start  input  1  level; starts execution from PC=0 when in IDLE
- imem_req  output  1  one-cycle fetch request pulse
- imem_addr  output  PC_W  word address of the fetch, held stable from FETCH until the instruction is latched
- imem_rdata  input  32  instruction word, sampled when imem_valid=1
- imem_valid  input  1  instruction-return strobe
- done  output  1  high while in DONE
- err  output  1  high while in ERROR
- pc  output  PC_W  current PC
- dbg_addr  input  5  register-file debug read index
- dbg_data  output  32  combinational read of register dbg_addr; 0 if index >= NREG

Behaviour:
- Reset: rst is asynchronous, active-low; clock is clk. On reset the FSM goes to IDLE; done=0, err=0, imem_req=0, imem_addr=0, pc=0; all registers and the instruction latch are cleared. Reset mid-fetch discards any in-flight imem_valid.
- States: IDLE, FETCH, WAIT, EXECUTE, WRITEBACK, DONE, ERROR.
- IDLE: when start=1, set pc=0 and go to FETCH. Registers are not cleared by start.
- FETCH (1 cycle): imem_req=1, imem_addr=pc, clear the wait counter, go to WAIT.
- WAIT:
  - If imem_valid=1, latch imem_rdata and go to EXECUTE.
  - Otherwise increment the counter; when the counter reaches WAIT_MAX, go to ERROR.
  - imem_valid outside WAIT is ignored.
- EXECUTE (1 cycle): decode, read rs1/rs2, compute the ALU result, branch condition and next PC; register all of them.
  - Illegal instruction goes to ERROR with no register write. Illegal means:
    - opcode not one of OP, OP-IMM, LUI, BRANCH, JAL, SYSTEM;
    - any register index >= NREG;
    - OP funct7 not 0000000 or 0100000, or funct7=0100000 with funct3 other than 000/101;
    - BRANCH funct3 010 or 011.
  - EBREAK (0x00100073) goes to DONE. Any other SYSTEM encoding goes to ERROR.
- Supported operations:
  - OP: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND.
  - OP-IMM: ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI.
  - I-immediates are sign-extended from bit 31. SLTIU compares unsigned against the sign-extended immediate. Shift amount is imm[4:0] / rs2[4:0]. SRAI is selected by imm[10].
  - LUI: rd = {imm[31:12], 12'b0}.
  - BRANCH: BEQ, BNE, BLT, BGE, BLTU, BGEU. B-immediate is sign-extended. Taken: next pc = pc + (imm>>>2); not taken: pc+1.
  - JAL: rd = (pc+1)<<2, truncated to 32 bits; next pc = pc + (imm>>>2).
  - A branch or jump immediate with imm[1:0] != 0 goes to ERROR.
- PC arithmetic is modulo 2^PC_W: wraps silently, no error.
- WRITEBACK (1 cycle):
  - Write rd if the instruction writes and rd != 0; writes to x0 are dropped.
  - Update pc.
  - If the new pc == END_PC, go to DONE; otherwise go to FETCH.
- DONE / ERROR: the flag is held high. When start=0 the FSM returns to IDLE on the next edge; the flag clears on leaving the state.
- Timing: an instruction takes 4 cycles plus memory latency (FETCH, WAIT >= 1, EXECUTE, WRITEBACK). A register written in WRITEBACK is visible to the next instruction's EXECUTE.

Test Plan:
- Zero-latency memory (imem_valid the cycle after imem_req). Program: 0x00300513 (ADDI x10,x0,3), 0xFFF00593 (ADDI x11,x0,-1), 0x40B50633 (SUB x12,x10,x11), 0x4045D693 (SRAI x13,x11,4), 0x12345737 (LUI x14,0x12345), 0x00100073 (EBREAK). Required: x10=3, x11=0xFFFFFFFF, x12=4, x13=0xFFFFFFFF, x14=0x12345000; done=1 after 24 cycles from the first FETCH.
- Branch/jump. 0x00B50463 (BEQ x10,x11,+8) with x10=x11=5 at pc=2 → next fetch addr 4; with x10≠x11 → addr 3. 0xFF9FF0EF (JAL x1,-8) at pc=6 → next fetch addr 4, x1=28.
- Wait states and timeout. imem_valid delayed 3 cycles → correct result, no err. imem_valid withheld → err=1 exactly WAIT_MAX cycles after WAIT entry; start low → IDLE, err=0.
- Illegal and x0 writes. 0x00000000 → err=1, no register changes. 0x00100013 (ADDI x0,x0,1) → x0 reads 0 via dbg_data.
- Halt and wrap. END_PC=3, program of 3 ADDIs → done after the third WRITEBACK. With END_PC unreachable, pc=255 → wraps to 0.
- Reset mid-WAIT: drop rst while in WAIT, then assert imem_valid after release → state IDLE, pc=0, registers 0, no write, done=err=0.
